seq_adder_sub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor. It is the clocked successor to the team's single-bit full adder.
- Adds or subtracts two W-bit operands D bits per cycle, using a ripple of D full-adder cells plus a registered carry.
- Has a start/busy/done handshake, so arithmetic blocks upstream can trade area for latency.
- Reports carry-out (no-borrow in subtract mode) and signed overflow.

---
 rtl/seq_adder_sub.sv | 129 ++++++++++++
 tb/tb_seq_adder_sub.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_sub.sv
// Multi-cycle adder/subtractor: processes D bits per cycle through a ripple of
// D full-adder cells, with a registered carry between slices.
module seq_adder_sub #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int N  = W / D;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           c_q, c_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [D-1:0]   slice_s;
  logic           slice_cmsb;
  logic           slice_cout;
  logic [W-1:0]   res_next;
  logic           last;

  // Operand registers shift right by D each slice, so the active slice is always bits [D-1:0].
  always_comb begin
    logic c;
    c          = c_q;
    slice_s    = '0;
    slice_cmsb = 1'b0;
    for (int j = 0; j < D; j++) begin
      slice_s[j] = a_q[j] ^ b_q[j] ^ c;
      if (j == D - 1) slice_cmsb = c;
      c = (a_q[j] & b_q[j]) | (c & (a_q[j] ^ b_q[j]));
    end
    slice_cout = c;
  end

  // New slice bits enter at the top of the result register and migrate down.
  assign res_next = (res_q >> D) | (W'(slice_s) << (W - D));
  assign last     = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        a_d   = a_q >> D;
        b_d   = b_q >> D;
        res_d = res_next;
        c_d   = slice_cout;
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_cmsb;
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          idx_d   = '0;
          res_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder_sub.sv
// Bench for seq_adder_sub: directed vectors and handshake sequences on W=8/D=2,
// plus randomized sweeps on W=16 with D=1 and D=16 against an arithmetic model.
module tb_seq_adder_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy_s, done_s, cout_s, ovf_s;
  logic [15:0] sum_s;
  logic        busy_w, done_w, cout_w, ovf_w;
  logic [15:0] sum_w;

  seq_adder_sub #(.W(8), .D(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  seq_adder_sub #(.W(16), .D(1)) u_dut16s (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s));

  seq_adder_sub #(.W(16), .D(16)) u_dut16w (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input int w, input logic s, input logic [31:0] ua, input logic [31:0] ub,
                       input logic ci, output logic [31:0] es, output logic ec, output logic eo);
    longint x, y, m, half, sx, sy, r, sr;
    x    = longint'(ua);
    y    = longint'(ub);
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sx   = (x >= half) ? x - 2 * half : x;
    sy   = (y >= half) ? y - 2 * half : y;
    if (s) begin
      r  = x - y;
      ec = (x >= y);
      sr = sx - sy;
    end else begin
      r  = x + y + longint'(ci);
      ec = ((r >> w) & 1) != 0;
      sr = sx + sy + longint'(ci);
    end
    es = 32'(r & m);
    eo = (sr >= half) || (sr < -half);
  endtask

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci,
                      output logic [7:0] rs, output logic rc, output logic ro,
                      output int nbusy, output int ndone, output logic held);
    logic [7:0] prev;
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y; cin = ci;
    @(negedge clk);
    start = 1'b0;
    prev = sum; nbusy = 0; ndone = 0; held = 1'b1;
    rs = 'x; rc = 1'bx; ro = 1'bx;
    for (int c = 0; c < 20; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        rs = sum; rc = cout; ro = ovf;
        break;
      end
      if (sum !== prev) held = 1'b0;
      @(negedge clk);
    end
    repeat (2) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  typedef struct {
    logic       s;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  rs;
    logic        rc, ro, held;
    int          nb, nd, nb2, nd2, dcyc;
    logic [31:0] es;
    logic        ec, eo;
    logic [15:0] rs_s, rs_w;
    logic        rc_s, ro_s, rc_w, ro_w;

    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_sum",  32'(sum),  0);
    chk("reset_cout", 32'(cout), 0);
    chk("reset_ovf",  32'(ovf),  0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ci, rs, rc, ro, nb, nd, held);
      chk($sformatf("vec%0d_sum", i),   32'(rs), 32'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i),  32'(rc), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_ovf", i),   32'(ro), 32'(vecs[i].eo));
      chk($sformatf("vec%0d_busy", i),  32'(nb), 4);
      chk($sformatf("vec%0d_done", i),  32'(nd), 1);
      chk($sformatf("vec%0d_held", i),  32'(held), 1);
    end

    // Start while busy is ignored.
    @(negedge clk); start = 1'b1; sub = 1'b0; cin = 1'b0; a = 8'h01; b = 8'h01;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 8'h7F; b = 8'h7F;
    @(negedge clk); start = 1'b0;
    nd = 0; rs = '0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin nd++; rs = sum; end
      @(negedge clk);
    end
    chk("busy_ignore_done", 32'(nd), 1);
    chk("busy_ignore_sum",  32'(rs), 32'h02);
    chk("busy_ignore_idle", 32'(busy), 0);

    // Back-to-back accept in the DONE cycle.
    @(negedge clk); start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        nd = 1; rs = sum;
        start = 1'b1; a = 8'h03; b = 8'h04;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_first_done", 32'(nd), 1);
    chk("b2b_first_sum",  32'(rs), 32'h30);
    @(negedge clk); start = 1'b0;
    chk("b2b_no_idle", 32'(busy), 1);
    nb = 1; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin nd = 1; rs = sum; break; end
    end
    chk("b2b_busy",   32'(nb), 4);
    chk("b2b_done",   32'(nd), 1);
    chk("b2b_sum",    32'(rs), 32'h07);

    // Reset during the second busy cycle aborts the operation.
    @(negedge clk); start = 1'b1; a = 8'h55; b = 8'h11;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum",  32'(sum),  0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_ovf",  32'(ovf),  0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    run8(1'b0, 8'h55, 8'h11, 1'b0, rs, rc, ro, nb, nd, held);
    chk("after_abort_sum",  32'(rs), 32'h66);
    chk("after_abort_busy", 32'(nb), 4);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk); rst_n = 1'b0; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    chk("rst_wins_busy", 32'(busy), 0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_wins_no_done", 32'(nd), 0);

    // Random W=8 operations against the model.
    for (int i = 0; i < 200; i++) begin
      logic s8, c8;
      logic [7:0] x8, y8;
      s8 = 1'($urandom); c8 = 1'($urandom);
      x8 = 8'($urandom); y8 = 8'($urandom);
      run8(s8, x8, y8, c8, rs, rc, ro, nb, nd, held);
      model(8, s8, 32'(x8), 32'(y8), c8, es, ec, eo);
      chk("rnd8_sum",  32'(rs), es);
      chk("rnd8_cout", 32'(rc), 32'(ec));
      chk("rnd8_ovf",  32'(ro), 32'(eo));
      chk("rnd8_done", 32'(nd), 1);
    end

    // W=16 sweep: D=1 and D=16 instances share the same stimulus.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start16 = 1'b1; sub16 = 1'($urandom); cin16 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (i < 4) begin a16 = (i[0]) ? 16'h8000 : 16'hFFFF; b16 = (i[1]) ? 16'h0001 : 16'hFFFF; end
      @(negedge clk);
      start16 = 1'b0;
      nb = 0; nd = 0; nb2 = 0; nd2 = 0; dcyc = -1;
      rs_s = 'x; rc_s = 1'bx; ro_s = 1'bx; rs_w = 'x; rc_w = 1'bx; ro_w = 1'bx;
      for (int c = 0; c < 20; c++) begin
        if (busy_s) nb++;
        if (busy_w) nb2++;
        if (done_s) begin nd++; rs_s = sum_s; rc_s = cout_s; ro_s = ovf_s; end
        if (done_w) begin nd2++; rs_w = sum_w; rc_w = cout_w; ro_w = ovf_w; dcyc = c; end
        @(negedge clk);
      end
      model(16, sub16, 32'(a16), 32'(b16), cin16, es, ec, eo);
      chk("d1_sum",   32'(rs_s), es);
      chk("d1_cout",  32'(rc_s), 32'(ec));
      chk("d1_ovf",   32'(ro_s), 32'(eo));
      chk("d1_busy",  32'(nb), 16);
      chk("d1_done",  32'(nd), 1);
      chk("d16_sum",  32'(rs_w), es);
      chk("d16_cout", 32'(rc_w), 32'(ec));
      chk("d16_ovf",  32'(ro_w), 32'(eo));
      chk("d16_busy", 32'(nb2), 1);
      chk("d16_done", 32'(nd2), 1);
      chk("d16_done_cycle", 32'(dcyc), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
